// File: rtl/muldiv_seq_pkg.sv
// Shared encodings for the multiply/divide sequencer: op codes, FSM states
// and the operand magnitude helper used by the signed operations.
package muldiv_seq_pkg;

  localparam int MD_OP_W = 2;

  typedef enum logic [MD_OP_W-1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_ITER = 2'd2,
    S_FIX  = 2'd3
  } md_state_e;

  // Two's-complement magnitude; 32'h8000_0000 maps to itself, read as 2^31 unsigned.
  function automatic logic [31:0] md_mag(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_addsub.sv
// Shared arithmetic unit: full-width add for shift-add multiply, or a
// (XLEN+1)-bit trial subtract with borrow for restoring division.
module muldiv_addsub #(
  parameter int XLEN = 32
) (
  input  logic              sub_i,
  input  logic [2*XLEN-1:0] x_i,
  input  logic [2*XLEN-1:0] y_i,
  output logic [2*XLEN-1:0] sum_o,
  output logic              borrow_o
);

  logic [XLEN+1:0] diff_s;

  // Select between the 64-bit sum and the 33-bit difference with borrow.
  always_comb begin
    diff_s = {1'b0, x_i[XLEN:0]} - {1'b0, y_i[XLEN:0]};
    if (sub_i) begin
      sum_o    = {{(XLEN-1){1'b0}}, diff_s[XLEN:0]};
      borrow_o = diff_s[XLEN+1];
    end else begin
      sum_o    = x_i + y_i;
      borrow_o = 1'b0;
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO pair.
// Optional macro MULDIV_EARLY_EXIT_EN: a multiply leaves ITER as soon as the
// remaining multiplier is zero; otherwise every operation runs ITERS cycles.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int ITERS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            wr_hi,
  input  logic            wr_lo,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int DW    = 2 * XLEN;
  localparam int CNT_W = $clog2(ITERS);

  md_state_e         state_q, state_d;
  md_op_e            op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
  logic              sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic              dz_q, dz_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]     prod_q, prod_d;      // product, or remainder in [XLEN:0]
  logic [DW-1:0]     mcand_q, mcand_d;    // multiplicand, or divisor in [XLEN-1:0]
  logic [XLEN-1:0]   mplier_q, mplier_d;  // multiplier, or dividend/quotient
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic              busy_q, busy_d, done_q, done_d;

  logic              is_div_s, mul_exit_s;
  logic [XLEN:0]     rem_shift_s;
  logic              add_sub_s, add_borrow_s;
  logic [DW-1:0]     add_x_s, add_y_s, add_sum_s;
  logic              sa_s, sb_s;
  logic [XLEN-1:0]   mag_a_s, mag_b_s, fix_quo_s, fix_rem_s;
  logic [DW-1:0]     fix_prod_s;

  assign is_div_s = op_q[1];

`ifdef MULDIV_EARLY_EXIT_EN
  assign mul_exit_s = !is_div_s && (mplier_q[XLEN-1:1] == {(XLEN-1){1'b0}});
`else
  assign mul_exit_s = 1'b0;
`endif

  // Route either the multiply accumulate or the division trial subtract to the shared unit.
  always_comb begin
    rem_shift_s = {prod_q[XLEN-1:0], mplier_q[XLEN-1]};
    if (is_div_s) begin
      add_sub_s = 1'b1;
      add_x_s   = {{(XLEN-1){1'b0}}, rem_shift_s};
      add_y_s   = {{(XLEN-1){1'b0}}, mcand_q[XLEN:0]};
    end else begin
      add_sub_s = 1'b0;
      add_x_s   = prod_q;
      add_y_s   = mcand_q;
    end
  end

  muldiv_addsub #(.XLEN(XLEN)) u_addsub (
    .sub_i    (add_sub_s),
    .x_i      (add_x_s),
    .y_i      (add_y_s),
    .sum_o    (add_sum_s),
    .borrow_o (add_borrow_s)
  );

  // Next-state and datapath logic for IDLE / PREP / ITER / FIX.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    dz_d       = dz_q;
    cnt_d      = cnt_q;
    prod_d     = prod_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    sa_s       = !op_q[0] && a_q[XLEN-1];
    sb_s       = !op_q[0] && b_q[XLEN-1];
    mag_a_s    = md_mag(a_q, sa_s);
    mag_b_s    = md_mag(b_q, sb_s);
    fix_prod_s = (sign_a_q ^ sign_b_q) ? (~prod_q + {{(DW-1){1'b0}}, 1'b1}) : prod_q;
    fix_quo_s  = (sign_a_q ^ sign_b_q) ? md_mag(mplier_q, 1'b1) : mplier_q;
    fix_rem_s  = sign_a_q ? md_mag(prod_q[XLEN-1:0], 1'b1) : prod_q[XLEN-1:0];

    case (state_q)
      S_IDLE: begin
        hi_d = wr_hi ? wdata : hi_q;
        lo_d = wr_lo ? wdata : lo_q;
        if (start) begin
          state_d = S_PREP;
          op_d    = md_op_e'(op);
          a_d     = a;
          b_d     = b;
          busy_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PREP: begin
        sign_a_d = sa_s;
        sign_b_d = sb_s;
        cnt_d    = CNT_W'(ITERS - 1);
        prod_d   = {DW{1'b0}};
        if (is_div_s) begin
          mcand_d  = {{XLEN{1'b0}}, mag_b_s};
          mplier_d = mag_a_s;
          if (b_q == {XLEN{1'b0}}) begin
            dz_d    = 1'b1;
            state_d = S_FIX;
          end else begin
            dz_d    = 1'b0;
            state_d = S_ITER;
          end
        end else begin
          mcand_d  = {{XLEN{1'b0}}, mag_a_s};
          mplier_d = mag_b_s;
          dz_d     = 1'b0;
          state_d  = S_ITER;
        end
      end
      S_ITER: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (is_div_s) begin
          if (add_borrow_s) begin
            prod_d   = {{(XLEN-1){1'b0}}, rem_shift_s};
            mplier_d = {mplier_q[XLEN-2:0], 1'b0};
          end else begin
            prod_d   = {{(XLEN-1){1'b0}}, add_sum_s[XLEN:0]};
            mplier_d = {mplier_q[XLEN-2:0], 1'b1};
          end
        end else begin
          prod_d   = mplier_q[0] ? add_sum_s : prod_q;
          mcand_d  = {mcand_q[DW-2:0], 1'b0};
          mplier_d = {1'b0, mplier_q[XLEN-1:1]};
        end
        if ((cnt_q == {CNT_W{1'b0}}) || mul_exit_s) begin
          state_d = S_FIX;
        end else begin
          state_d = S_ITER;
        end
      end
      S_FIX: begin
        if (dz_q) begin
          hi_d = a_q;
          lo_d = {XLEN{1'b1}};
        end else if (is_div_s) begin
          hi_d = fix_rem_s;
          lo_d = fix_quo_s;
        end else begin
          hi_d = fix_prod_s[DW-1:XLEN];
          lo_d = fix_prod_s[XLEN-1:0];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= MD_MULT;
      a_q      <= {XLEN{1'b0}};
      b_q      <= {XLEN{1'b0}};
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      dz_q     <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
      prod_q   <= {DW{1'b0}};
      mcand_q  <= {DW{1'b0}};
      mplier_q <= {XLEN{1'b0}};
      hi_q     <= {XLEN{1'b0}};
      lo_q     <= {XLEN{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      dz_q     <= dz_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: expected {hi,lo,latency} pushed at issue,
// popped and compared when done pulses.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        wr_hi = 1'b0;
  logic        wr_lo = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] hilo;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  muldiv_seq dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference result {hi,lo} from native wide arithmetic.
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv);
    logic signed [63:0] sa, sb, q, r;
    logic [63:0] res;
    sa  = {{32{av[31]}}, av};
    sb  = {{32{bv[31]}}, bv};
    res = 64'd0;
    case (o)
      2'd0: res = sa * sb;
      2'd1: res = {32'd0, av} * {32'd0, bv};
      2'd2: begin
        if (bv == 32'd0) res = {av, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (bv == 32'd0) res = {av, 32'hFFFF_FFFF};
        else res = {av % bv, av / bv};
      end
    endcase
    return res;
  endfunction

  // Expected edges from the start edge to the edge that raises done.
  function automatic int ref_lat(input logic [1:0] o, input logic [31:0] bv);
    logic [31:0] mag;
    int nb;
    mag = bv;
    nb  = 0;
    if (o[1] && (bv == 32'd0)) return 2;
`ifdef MULDIV_EARLY_EXIT_EN
    if (!o[1]) begin
      if (o == 2'd0 && bv[31]) mag = ~bv + 32'd1;
      while (mag != 32'd0) begin
        nb++;
        mag = mag >> 1;
      end
      if (nb == 0) nb = 1;
      return 2 + nb;
    end
`endif
    return 34 + nb + int'(mag == 32'hFFFF_FFFF && 1'b0);
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input int poke_at, input bit same_wr);
    exp_t e, got_e;
    int   n;
    bit   seen, busy_ok;
    e.hilo = ref_model(o, av, bv);
    e.lat  = ref_lat(o, bv);
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    if (same_wr) begin wr_lo = 1'b1; wdata = 32'h5A5A_0001; end
    @(posedge clk); #1;
    start = 1'b0; wr_lo = 1'b0;
    op = 2'($urandom_range(3)); a = $urandom; b = $urandom;
    check_val("busy_after_start", busy, 1);
    if (same_wr) check_val("same_cycle_wr_lo", lo, 32'h5A5A_0001);
    n = 0; seen = 1'b0; busy_ok = 1'b1;
    while (!seen && n < 100) begin
      if (poke_at > 0 && n == poke_at - 1) begin
        @(negedge clk);
        start = 1'b1; op = 2'd3; a = 32'd99; b = 32'd7;
        wr_hi = 1'b1; wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        start = 1'b0; wr_hi = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
      n++;
      if (done) seen = 1'b1;
      else if (!busy) busy_ok = 1'b0;
    end
    check_val("done_seen", seen, 1);
    got_e = sb_q.pop_front();
    if (seen) begin
      check_val("hi", hi, got_e.hilo[63:32]);
      check_val("lo", lo, got_e.hilo[31:0]);
      check_val("latency", n, got_e.lat);
      check_val("busy_at_done", busy, 0);
      check_val("busy_held", busy_ok, 1);
      @(posedge clk); #1;
      check_val("done_one_cycle", done, 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_hi", hi, 0);
    check_val("rst_lo", lo, 0);

    // MTLO in IDLE
    @(negedge clk); wr_lo = 1'b1; wdata = 32'h0000_1234;
    @(posedge clk); #1;
    wr_lo = 1'b0;
    check_val("mtlo_lo", lo, 32'h0000_1234);
    check_val("mtlo_hi_kept", hi, 0);

    // Directed operations
    run_op(2'd0, 32'd7, 32'd6, 0, 0);
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0, 0);
    run_op(2'd3, 32'd7, 32'd2, 0, 0);
    run_op(2'd3, 32'd5, 32'd0, 0, 0);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op(2'd2, 32'hFFFF_FF00, 32'd0, 0, 0);
    run_op(2'd0, 32'h8000_0000, 32'd3, 0, 0);
    run_op(2'd0, 32'd9, 32'd3, 0, 0);
    run_op(2'd0, 32'd12345, 32'd0, 0, 0);

    // start and MTHI while busy are ignored
    run_op(2'd0, 32'd12345, 32'hFFFE_7960, 10, 0);
    // MTLO together with start lands, then gets overwritten
    run_op(2'd1, 32'h0001_0003, 32'h8000_0011, 0, 1);

    for (int i = 0; i < 20; i++) begin
      ro = 2'($urandom_range(3));
      ra = $urandom;
      case ($urandom_range(3))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(15));
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb, 0, 0);
    end

    // Reset mid-operation
    @(negedge clk); wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'h0BAD_F00D;
    @(negedge clk); wr_hi = 1'b0; wr_lo = 1'b0;
    check_val("pre_rst_hi", hi, 32'h0BAD_F00D);
    @(negedge clk); start = 1'b1; op = 2'd0; a = 32'd1234; b = 32'h4000_0000;
    @(posedge clk); #1; start = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    #1;
    check_val("midrst_busy", busy, 0);
    check_val("midrst_hi", hi, 0);
    check_val("midrst_lo", lo, 0);
    @(negedge clk); rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check_val("no_done_after_rst", ndone, 0);
    check_val("lo_after_rst", lo, 0);

    check_val("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
